// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the systolic array sequencer.
// Default parameters are consumed by systolic_ctrl and may be overridden per instance.
package systolic_pkg;

  localparam int DEF_ARRAY_N    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_K_MAX      = 16;

  // Wavefront needs 2N-1 extra cycles after the last read to reach PE[N-1][N-1].
  localparam int DRAIN_CYCLES = 2 * DEF_ARRAY_N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int drain_cycles_for(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew.sv
// skew_line: DEPTH-stage shift register of {valid, data} used to stagger one array lane.
// DEPTH = 0 degenerates to a plain wire.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             dly_valid,
  output logic [WIDTH-1:0] dly_data
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, flush};
    assign dly_valid   = src_valid;
    assign dly_data    = src_data;
  end else begin : g_pipe
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             stage_valid_next;
      logic [WIDTH-1:0] stage_data_next;
      logic             stage_valid_reg;
      logic [WIDTH-1:0] stage_data_reg;

      if (gi == 0) begin : g_head
        assign stage_valid_next = src_valid;
        assign stage_data_next  = src_data;
      end else begin : g_body
        assign stage_valid_next = g_stage[gi-1].stage_valid_reg;
        assign stage_data_next  = g_stage[gi-1].stage_data_reg;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_valid_reg <= 1'b0;
          stage_data_reg  <= '0;
        end else if (flush) begin
          stage_valid_reg <= 1'b0;
          stage_data_reg  <= '0;
        end else begin
          stage_valid_reg <= stage_valid_next;
          stage_data_reg  <= stage_data_next;
        end
      end
    end

    assign dly_valid = g_stage[DEPTH-1].stage_valid_reg;
    assign dly_data  = g_stage[DEPTH-1].stage_data_reg;
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary PE array: reads k operand slices,
// skews them diagonally onto the array edges, waits for the drain and pulses done.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_N    = DEF_ARRAY_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K_MAX      = DEF_K_MAX,
  parameter int KW         = $clog2(K_MAX + 1),
  parameter int AW         = $clog2(K_MAX)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [KW-1:0]                 cfg_k,
  input  logic                          abort,
  output logic                          buf_rd_en,
  output logic [AW-1:0]                 buf_rd_addr,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] a_rd_data,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] b_rd_data,
  output logic [ARRAY_N*DATA_WIDTH-1:0] arr_left,
  output logic [ARRAY_N*DATA_WIDTH-1:0] arr_top,
  output logic                          busy,
  output logic                          done
);

  localparam int DRAIN_LEN = drain_cycles_for(ARRAY_N);
  localparam int DW        = $clog2(2 * ARRAY_N);

  state_t        state_reg, state_next;
  logic [KW-1:0] k_reg, k_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] drain_reg, drain_next;
  logic          valid_reg;

  logic [KW-1:0] k_req;
  logic          addr_last;
  logic          drain_last;

  // Oversized requests are clamped rather than rejected.
  assign k_req      = (cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : cfg_k;
  assign addr_last  = (KW'(addr_reg) == (k_reg - KW'(1)));
  assign drain_last = (drain_reg == DW'(DRAIN_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      addr_reg  <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      addr_reg  <= addr_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    addr_next  = addr_reg;
    drain_next = drain_reg;
    if (abort) begin
      state_next = IDLE;
      addr_next  = '0;
      drain_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_next = '0;
            if (k_req == '0) begin
              state_next = DONE;
            end else begin
              state_next = FEED;
              k_next     = k_req;
            end
          end
        end
        FEED: begin
          if (addr_last) begin
            state_next = DRAIN;
            addr_next  = '0;
            drain_next = '0;
          end else begin
            addr_next = addr_reg + AW'(1);
          end
        end
        DRAIN: begin
          if (drain_last) begin
            state_next = DONE;
            drain_next = '0;
          end else begin
            drain_next = drain_reg + DW'(1);
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign buf_rd_en   = (state_reg == FEED);
  assign buf_rd_addr = addr_reg;
  assign busy        = (state_reg == FEED) || (state_reg == DRAIN);
  assign done        = (state_reg == DONE);

  // Buffer data arrives one cycle after the strobe; this bit marks it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= buf_rd_en && !abort;
    end
  end

  for (genvar gi = 0; gi < ARRAY_N; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] row_src, col_src;
    logic [DATA_WIDTH-1:0] row_dly, col_dly;
    logic                  row_vld, col_vld;

    assign row_src = valid_reg ? a_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign col_src = valid_reg ? b_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

    skew_line #(
      .DEPTH(gi),
      .WIDTH(DATA_WIDTH)
    ) u_row_skew (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (abort),
      .src_valid(valid_reg),
      .src_data (row_src),
      .dly_valid(row_vld),
      .dly_data (row_dly)
    );

    skew_line #(
      .DEPTH(gi),
      .WIDTH(DATA_WIDTH)
    ) u_col_skew (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (abort),
      .src_valid(valid_reg),
      .src_data (col_src),
      .dly_valid(col_vld),
      .dly_data (col_dly)
    );

    // Lanes outside their valid window are forced to zero.
    assign arr_left[gi*DATA_WIDTH +: DATA_WIDTH] = row_vld ? row_dly : '0;
    assign arr_top[gi*DATA_WIDTH +: DATA_WIDTH]  = col_vld ? col_dly : '0;
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: a job-level timing model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int KM = 16;
  localparam int KW = 5;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [KW-1:0]   cfg_k = '0;
  logic            buf_rd_en;
  logic [AW-1:0]   buf_rd_addr;
  logic [N*W-1:0]  a_rd_data = '0;
  logic [N*W-1:0]  b_rd_data = '0;
  logic [N*W-1:0]  arr_left, arr_top;
  logic            busy, done;

  systolic_ctrl #(
    .ARRAY_N   (N),
    .DATA_WIDTH(W),
    .K_MAX     (KM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_k      (cfg_k),
    .abort      (abort),
    .buf_rd_en  (buf_rd_en),
    .buf_rd_addr(buf_rd_addr),
    .a_rd_data  (a_rd_data),
    .b_rd_data  (b_rd_data),
    .arr_left   (arr_left),
    .arr_top    (arr_top),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Operand buffers: registered read, junk on the bus whenever nothing was read.
  logic [W-1:0] amem [KM][N];
  logic [W-1:0] bmem [KM][N];
  logic          pend_en = 1'b0;
  logic [AW-1:0] pend_addr = '0;

  always @(negedge clk) begin
    pend_en   = buf_rd_en;
    pend_addr = buf_rd_addr;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      a_rd_data[i*W +: W] = pend_en ? amem[pend_addr][i] : W'(224 + i);
      b_rd_data[i*W +: W] = pend_en ? bmem[pend_addr][i] : W'(240 + i);
    end
  end

  // Job-level model: each accepted job is (start cycle, k, abort cycle).
  typedef struct {
    int s;
    int k;
    int ab;
  } job_t;
  job_t jobs[$];

  function automatic int job_end(input job_t j);
    int e;
    e = (j.k == 0) ? j.s + 1 : j.s + j.k + 2 * N;
    if (j.ab < e) e = j.ab;
    return e;
  endfunction

  // Observation counters consulted by the directed scenarios.
  int rd_cnt, busy_cnt, done_cnt, done_first, done_last, rd_first, rd_last;
  int l3_cnt, l3_first, l3_last;

  task automatic clr_mon();
    rd_cnt = 0; busy_cnt = 0; done_cnt = 0; done_first = -1; done_last = -1;
    rd_first = -1; rd_last = -1; l3_cnt = 0; l3_first = -1; l3_last = -1;
  endtask

  always @(negedge clk) begin
    logic [N*W-1:0] exp_left, exp_top;
    logic           exp_busy, exp_done, exp_rd;
    int             exp_addr, t, e;
    bit             idle_now;
    job_t           nj;
    if (!rst_n) begin
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_rd_en", buf_rd_en, 0);
      check("reset_left", arr_left, 0);
      check("reset_top", arr_top, 0);
      jobs.delete();
    end else begin
      exp_left = '0; exp_top = '0; exp_busy = 0; exp_done = 0; exp_rd = 0; exp_addr = 0;
      idle_now = 1;
      foreach (jobs[q]) begin
        e = job_end(jobs[q]);
        if (cyc > jobs[q].s && cyc <= e) begin
          idle_now = 0;
          if (jobs[q].k > 0 && cyc <= jobs[q].s + jobs[q].k) begin
            exp_rd = 1;
            exp_addr = cyc - jobs[q].s - 1;
          end
          if (jobs[q].k > 0 && cyc <= jobs[q].s + jobs[q].k + 2 * N - 1) exp_busy = 1;
          if (cyc == ((jobs[q].k == 0) ? jobs[q].s + 1 : jobs[q].s + jobs[q].k + 2 * N)) exp_done = 1;
          for (int i = 0; i < N; i++) begin
            t = cyc - jobs[q].s - 2 - i;
            if (t >= 0 && t < jobs[q].k) begin
              exp_left[i*W +: W] = amem[t][i];
              exp_top[i*W +: W]  = bmem[t][i];
            end
          end
        end
      end
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("rd_en", buf_rd_en, exp_rd);
      if (exp_rd) check("rd_addr", buf_rd_addr, exp_addr);
      check("arr_left", arr_left, exp_left);
      check("arr_top", arr_top, exp_top);

      if (buf_rd_en) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_first < 0) done_first = cyc;
        done_last = cyc;
      end
      if (arr_left[3*W +: W] != '0) begin
        l3_cnt++;
        if (l3_first < 0) l3_first = cyc;
        l3_last = cyc;
      end

      if (abort) begin
        foreach (jobs[q]) if (cyc > jobs[q].s && cyc <= job_end(jobs[q])) jobs[q].ab = cyc;
      end else if (start && idle_now) begin
        nj.s  = cyc;
        nj.k  = (int'(cfg_k) > KM) ? KM : int'(cfg_k);
        nj.ab = 1 << 30;
        jobs.push_back(nj);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int k, input string tag, output int s);
    @(posedge clk);
    #1;
    start = 1'b1;
    cfg_k = KW'(k);
    s = cyc;
    $display("job %s: cfg_k=%0d start cycle %0d", tag, k, s);
    step(1);
    start = 1'b0;
  endtask

  task automatic fill_mem(input bit simple);
    for (int t = 0; t < KM; t++) begin
      for (int i = 0; i < N; i++) begin
        amem[t][i] = simple ? W'(1 + i) : W'(t * 16 + i + 1);
        bmem[t][i] = simple ? W'(2) : W'(200 - t * 8 - i);
      end
    end
  endtask

  initial begin
    int s, s2;
    fill_mem(1'b1);
    clr_mon();

    // 1: reset while idle
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t1_busy", busy, 0);
    check("t1_rd_en", buf_rd_en, 0);
    check("t1_left", arr_left, 0);
    #2 rst_n = 1'b1;
    clr_mon();
    step(10);
    check("t1_rd_cnt", rd_cnt, 0);
    check("t1_busy_cnt", busy_cnt, 0);
    check("t1_done_cnt", done_cnt, 0);

    // 2: standard k=4 job
    clr_mon();
    start_job(4, "k4", s);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t2_left_c5", arr_left, 32'h04030201);
    check("t2_top_c5", arr_top, 32'h02020202);
    @(negedge clk);
    check("t2_left_c6", arr_left, 32'h04030200);
    step(9);
    check("t2_done_cyc", done_last - s, 12);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_rd_first", rd_first - s, 1);
    check("t2_rd_last", rd_last - s, 4);
    check("t2_busy_cnt", busy_cnt, 11);
    check("t2_l3_first", l3_first - s, 5);
    check("t2_l3_last", l3_last - s, 8);
    check("t2_l3_cnt", l3_cnt, 4);

    // 3: k=0 and clamped k=20
    fill_mem(1'b0);
    clr_mon();
    start_job(0, "k0", s);
    step(4);
    check("t3_k0_done", done_first - s, 1);
    check("t3_k0_rd", rd_cnt, 0);
    clr_mon();
    start_job(20, "k20", s);
    step(28);
    check("t3_k20_rd", rd_cnt, 16);
    check("t3_k20_done", done_last - s, 24);

    // 4: abort mid-job, then abort together with start in idle
    clr_mon();
    start_job(8, "abort", s);
    step(2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    @(negedge clk);
    check("t4_busy", busy, 0);
    check("t4_rd_en", buf_rd_en, 0);
    check("t4_left", arr_left, 0);
    check("t4_top", arr_top, 0);
    step(20);
    check("t4_no_done", done_cnt, 0);
    clr_mon();
    abort = 1'b1;
    start = 1'b1;
    cfg_k = KW'(3);
    $display("job abort+start: cfg_k=3 cycle %0d", cyc);
    step(1);
    abort = 1'b0;
    start = 1'b0;
    step(5);
    check("t4_as_rd", rd_cnt, 0);
    check("t4_as_busy", busy_cnt, 0);

    // 5: start held high across two k=2 jobs
    clr_mon();
    start = 1'b1;
    cfg_k = KW'(2);
    s = cyc;
    $display("job held_start: cfg_k=2 start cycle %0d", s);
    step(16);
    start = 1'b0;
    step(10);
    check("t5_done_cnt", done_cnt, 2);
    check("t5_done1", done_first - s, 10);
    check("t5_done2", done_last - s, 21);
    check("t5_rd_cnt", rd_cnt, 4);

    // 6: asynchronous reset mid-job, then a clean job
    clr_mon();
    start_job(4, "reset_mid", s);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_rd_en", buf_rd_en, 0);
    check("t6_left", arr_left, 0);
    check("t6_top", arr_top, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step(3);
    check("t6_rd_cnt", rd_cnt, 4);
    check("t6_busy_cnt", busy_cnt, 5);
    check("t6_done_cnt", done_cnt, 0);
    clr_mon();
    start_job(4, "after_reset", s2);
    step(14);
    check("t6_done_cyc", done_last - s2, 12);
    check("t6_rd_after", rd_cnt, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for the N x N output-stationary PE array.
- On a start command, reads K operand slices from the A (row) and B (column) operand buffers.
- Applies the diagonal skew, so row/column lane i arrives i cycles after lane 0, and drives the array's left and top edges.
- Holds zero on every lane outside its valid window, then waits for the wavefront to drain and pulses done.
- Sits between the operand buffers / host control and the PE array top level.

Parameters:
ARRAY_N, 4, array dimension (number of row lanes and column lanes).
DATA_WIDTH, 8, operand width per lane.
K_MAX, 16, maximum reduction length per job.
KW, $clog2(K_MAX+1), width of the k configuration field.
AW, $clog2(K_MAX), buffer address width.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  job request; sampled only in IDLE.
cfg_k  in  KW  reduction length; latched on accepted start.
abort  in  1  synchronous soft cancel; forces IDLE and clears the skew pipeline.
buf_rd_en  out  1  read strobe to both operand buffers.
buf_rd_addr  out  AW  slice index 0..k-1.
a_rd_data  in  ARRAY_N*DATA_WIDTH  A slice, one element per row lane; valid 1 cycle after buf_rd_en.
b_rd_data  in  ARRAY_N*DATA_WIDTH  B slice, one element per column lane; valid 1 cycle after buf_rd_en.
arr_left  out  ARRAY_N*DATA_WIDTH  to the left_in of the column-0 PEs; lane i is row i.
arr_top  out  ARRAY_N*DATA_WIDTH  to the top_in of the row-0 PEs; lane j is column j.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when every PE has registered its last product.

Behaviour:
Reset (rst_n low, asynchronous):
- State = IDLE.
- All outputs 0.
- Skew registers and counters 0.

FSM states:
- IDLE: start=1 and cfg_k in 1..K_MAX -> latch k, go to FEED; busy=1 from the next cycle.
  - start with cfg_k=0 -> go to DONE directly: no reads, done pulses in the cycle after start.
  - cfg_k > K_MAX -> clamp to K_MAX.
- FEED: buf_rd_en=1, buf_rd_addr = 0,1,..,k-1 on consecutive cycles. After address k-1 -> DRAIN.
- DRAIN: a counter runs for 2*ARRAY_N-1 cycles, then -> DONE.
- DONE: done=1 and busy=0 for one cycle, then -> IDLE. A start in this cycle is ignored.

Timing (start sampled at edge 0):
- rd addr t issued at cycle t+1.
- Raw data is registered into lane 0 at cycle t+2.
- Lane i presents element t at cycle t+2+i via an i-deep shift register per lane.
- PE[r][c] sees operand t at cycle t+2+r+c and registers its product one cycle later.
- Last product lands at cycle k+2N; done is asserted in that cycle.

Skew and zero rules:
- Each lane carries a valid bit alongside its data.
- When a lane's valid bit is 0, the data driven is 0 (never stale buffer data).

Boundary and corner rules:
- start while busy: ignored, no queuing.
- abort in any state: next cycle state=IDLE, buf_rd_en=0, all skew registers 0, busy=0, no done pulse.
- abort together with start in IDLE: abort wins.
- Back-to-back jobs: the earliest next start is the cycle after done.
- Asynchronous reset mid-job: everything returns to reset values immediately; the buffers are not touched afterwards.
- Widths: the address counter never exceeds k-1; the drain counter width is $clog2(2*ARRAY_N).

Decomposition:
- Shared package systolic_pkg holds:
  - ARRAY_N, DATA_WIDTH, K_MAX defaults.
  - State encoding typedef (IDLE, FEED, DRAIN, DONE).
  - Derived constant DRAIN_CYCLES = 2*ARRAY_N-1.
- One sub-module, skew_line: a parameterised DEPTH-stage shift register of {valid, data} with asynchronous active-low reset and a synchronous flush.
  - Instantiate 2*ARRAY_N times, with DEPTH = lane index; DEPTH=0 is a wire.

Test Plan:
1. Reset during idle, then release: all outputs 0, busy=0, no buf_rd_en for 10 cycles.
2. N=4, k=4, A lane i = 1+i and B lane j = 2, for all t: buf_rd_en high on cycles 1-4 with addr 0-3; arr_left lane 3 nonzero on cycles 5-8 only; done exactly at cycle 12; busy high on cycles 1-11.
3. start with cfg_k=0: done at cycle 1, no buf_rd_en; with cfg_k=20 (>K_MAX=16): 16 reads, done at cycle 24.
4. abort asserted at cycle 3 of a k=8 job: cycle 4 has busy=0, buf_rd_en=0, arr_left/arr_top all 0, and no done pulse ever.
5. start held high continuously for two k=2 jobs: second job accepted in the cycle after the first done (cycle 11); the mid-job start is ignored; the second done occurs at cycle 21.
6. rst_n dropped at cycle 6 of a k=4 job: outputs 0 asynchronously; after release the block sits in IDLE and the next start runs the standard 12-cycle timing.
